// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock mode/command sequencer.
// No logic of its own; no latency.
// Backpressure is not applicable (types and helpers only).
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        OP_INC = 2'd0,
        OP_DEC = 2'd1,
        OP_CLR = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    localparam int NUM_DIGITS   = 6;
    localparam int DIG_SEC_ONES = 0;
    localparam int DIG_SEC_TENS = 1;
    localparam int DIG_MIN_ONES = 2;
    localparam int DIG_MIN_TENS = 3;
    localparam int DIG_HR_ONES  = 4;
    localparam int DIG_HR_TENS  = 5;

    // Digits blanked during the off phase of the blink for a given mode.
    function automatic logic [NUM_DIGITS-1:0] set_blank_mask(input state_e st);
        logic [NUM_DIGITS-1:0] mask;
        mask = '0;
        case (st)
            ST_SET_HR: begin
                mask[DIG_HR_TENS] = 1'b1;
                mask[DIG_HR_ONES] = 1'b1;
            end
            ST_SET_MIN: begin
                mask[DIG_MIN_TENS] = 1'b1;
                mask[DIG_MIN_ONES] = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-count filter, rise/fall strobes.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from a stable raw level to level/strobe.
// No backpressure; strobes are single-cycle and coincide with the first new level cycle.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          armed_q, armed_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer stages; they reset high so a button still held through
    // reset is not mistaken for a fresh press once reset drops.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Stable-level filter, only armed after the button has been seen released.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        armed_d = armed_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!armed_q) begin
            cnt_d   = '0;
            armed_d = !sync2_q;
        end else if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = !sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            armed_q <= armed_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM + single-writer command stream (tick and user adjustments) + digit blink mask.
// Latency: command valid one clk after the registered button strobe or sampled tick.
// Backpressure: cmd held while !cmd_ready; user events dropped, one tick kept pending. Option: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000,
    parameter int BLINK_CYCLES      = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       tick_1hz,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_field,
    output logic [1:0] cmd_op,
    output logic       run_en,
    output logic [5:0] blink_mask
);

    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int BL_W     = $clog2(BLINK_CYCLES + 1);

    logic mode_lvl, mode_rise, mode_fall;
    logic up_lvl, up_rise, up_fall;
    logic dn_lvl, dn_rise, dn_fall;
    logic unused_strobes;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .raw(btn_mode), .level(mode_lvl), .rise(mode_rise), .fall(mode_fall)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .raw(btn_up), .level(up_lvl), .rise(up_rise), .fall(up_fall)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .raw(btn_down), .level(dn_lvl), .rise(dn_rise), .fall(dn_fall)
    );

    assign unused_strobes = mode_rise ^ up_fall ^ dn_fall;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   mode_hold_q, mode_hold_d;
    logic                mode_long;
    logic                cmd_valid_q, cmd_valid_d;
    field_e              cmd_field_q, cmd_field_d;
    op_e                 cmd_op_q, cmd_op_d;
    logic                tick_pend_q, tick_pend_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                user_vld;
    field_e              user_fld;
    op_e                 user_op;
    logic                tick_evt;
    logic                reg_free;
    logic                adj_issued;
    logic                rpt_fire;

    // Mode-button hold timer, saturating so very long holds never wrap back to "short".
    always_comb begin
        mode_hold_d = '0;
        if (mode_lvl) begin
            mode_hold_d = (mode_hold_q == HOLD_W'(LONG_PRESS_CYCLES)) ? mode_hold_q : mode_hold_q + 1'b1;
        end
    end

    assign mode_long = (mode_hold_q >= HOLD_W'(LONG_PRESS_CYCLES));

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    logic [HOLD_W-1:0] rpt_hold_q, rpt_hold_d;

    assign rpt_fire = (state_q != ST_RUN) && (up_lvl ^ dn_lvl) &&
                      (rpt_hold_q == HOLD_W'(LONG_PRESS_CYCLES));

    // Auto-repeat timer: first repeat at the long-press threshold, then every repeat period.
    always_comb begin
        rpt_hold_d = '0;
        if ((state_q != ST_RUN) && (up_lvl ^ dn_lvl)) begin
            rpt_hold_d = rpt_fire ? HOLD_W'(LONG_PRESS_CYCLES - REPEAT_CYCLES) : rpt_hold_q + 1'b1;
        end
    end

    // Auto-repeat timer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rpt_hold_q <= '0;
        else       rpt_hold_q <= rpt_hold_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Mode FSM next state and the user command it requests this cycle.
    always_comb begin
        state_d  = state_q;
        user_vld = 1'b0;
        user_fld = FLD_SEC;
        user_op  = OP_INC;
        if (mode_fall) begin
            if (mode_long) begin
                state_d = ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN:    state_d = ST_SET_HR;
                    ST_SET_HR: state_d = ST_SET_MIN;
                    ST_SET_MIN: begin
                        state_d  = ST_RUN;
                        user_vld = 1'b1;
                        user_op  = OP_CLR;
                    end
                    default:   state_d = ST_RUN;
                endcase
            end
        end else if (state_q != ST_RUN) begin
            user_fld = (state_q == ST_SET_HR) ? FLD_HOUR : FLD_MIN;
            if (up_rise && !dn_lvl) begin
                user_vld = 1'b1;
                user_op  = OP_INC;
            end else if (dn_rise && !up_lvl) begin
                user_vld = 1'b1;
                user_op  = OP_DEC;
            end else if (rpt_fire) begin
                user_vld = 1'b1;
                user_op  = up_lvl ? OP_INC : OP_DEC;
            end
        end
    end

    assign tick_evt = tick_1hz && (state_q == ST_RUN);
    assign reg_free = !cmd_valid_q || cmd_ready;

    // Command register: a pending tick goes first, then user events, then a fresh tick.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_field_d = cmd_field_q;
        cmd_op_d    = cmd_op_q;
        tick_pend_d = tick_pend_q;
        adj_issued  = 1'b0;
        if (reg_free) begin
            if (tick_pend_q) begin
                cmd_valid_d = 1'b1;
                cmd_field_d = FLD_SEC;
                cmd_op_d    = OP_INC;
                tick_pend_d = tick_evt;
            end else if (user_vld) begin
                cmd_valid_d = 1'b1;
                cmd_field_d = user_fld;
                cmd_op_d    = user_op;
                adj_issued  = (user_op != OP_CLR);
            end else if (tick_evt) begin
                cmd_valid_d = 1'b1;
                cmd_field_d = FLD_SEC;
                cmd_op_d    = OP_INC;
            end else begin
                cmd_valid_d = 1'b0;
            end
        end else if (tick_evt) begin
            tick_pend_d = 1'b1;
        end
    end

    // Blink timer: restarts visible on mode change or an issued adjustment.
    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if ((state_d != state_q) || adj_issued || (state_q == ST_RUN)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            mode_hold_q   <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_field_q   <= FLD_SEC;
            cmd_op_q      <= OP_INC;
            tick_pend_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_hold_q   <= mode_hold_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_field_q   <= cmd_field_d;
            cmd_op_q      <= cmd_op_d;
            tick_pend_q   <= tick_pend_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_field  = cmd_field_q;
    assign cmd_op     = cmd_op_q;
    assign run_en     = (state_q == ST_RUN);
    assign blink_mask = blink_phase_q ? set_blank_mask(state_q) : '0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized button/tick sequences.
// Expected command streams come from an abstract mode model and a scoreboard queue.
// Transfers are collected at negedge; stall stability is checked continuously.
module tb_clock_set_ctrl;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam int RP = 8;
    localparam int BL = 6;

    // command encoding used by the scoreboard: field*4 + op
    localparam int F_SEC = 0, F_MIN = 1, F_HOUR = 2;
    localparam int O_INC = 0, O_DEC = 1, O_CLR = 2;

    logic       clk, reset;
    logic       btn_mode, btn_up, btn_down, tick_1hz;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_field, cmd_op;
    logic       run_en;
    logic [5:0] blink_mask;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP), .BLINK_CYCLES(BL)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .tick_1hz(tick_1hz), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_field(cmd_field),
        .cmd_op(cmd_op), .run_en(run_en), .blink_mask(blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int got_q[$];
    int exp_q[$];
    int m_state = 0;   // 0 = running, 1 = setting hours, 2 = setting minutes

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transfer collector and stall-stability monitor.
    logic stall_prev = 1'b0;
    int   prev_cmd   = 0;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                check("hold_stable", {27'd0, cmd_valid, cmd_field, cmd_op}, 16 + prev_cmd);
            if (cmd_valid && cmd_ready)
                got_q.push_back(int'(cmd_field) * 4 + int'(cmd_op));
            stall_prev <= cmd_valid && !cmd_ready;
            prev_cmd   <= int'(cmd_field) * 4 + int'(cmd_op);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    // Press a raw button for len cycles, then let debounce and FSM settle.
    task automatic press(input int which, input int len);
        drive_btn(which, 1'b1);
        cyc(len);
        drive_btn(which, 1'b0);
        cyc(14);
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(3);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_cmd"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Commands emitted by holding an adjust button for `held` debounced cycles.
    function automatic int adj_count(input int held);
        int n;
        n = 1;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        if (held > LP) n += 1 + (held - 1 - LP) / RP;
`endif
        return n;
    endfunction

    // Abstract model actions (press lengths chosen well inside short/long bands).
    task automatic act_mode(input int len);
        press(0, len);
        if (len >= LP) begin
            m_state = 0;
        end else begin
            if (m_state == 2) exp_q.push_back(F_SEC * 4 + O_CLR);
            m_state = (m_state + 1) % 3;
        end
    endtask

    task automatic act_adj(input int which, input int len);
        press(which, len);
        if (m_state != 0)
            repeat (adj_count(len))
                exp_q.push_back(((m_state == 1) ? F_HOUR : F_MIN) * 4 + ((which == 1) ? O_INC : O_DEC));
    endtask

    task automatic act_tick();
        pulse_tick();
        if (m_state == 0) exp_q.push_back(F_SEC * 4 + O_INC);
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0; cmd_ready = 1;
        cyc(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_field", cmd_field, 0);
        check("rst_op", cmd_op, 0);
        check("rst_run_en", run_en, 1);
        check("rst_blink", blink_mask, 0);
        reset = 1'b0;
        cyc(6);

        // 1 Hz tick while running
        act_tick();
        check("run_en_run", run_en, 1);
        check("blink_run", blink_mask, 0);
        compare_stream("tick");

        // Enter hour setting and watch the blink pattern from entry
        btn_mode = 1'b1;
        cyc(8);
        btn_mode = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!run_en) seen = 1;
        end
        check("enter_set_hr", seen, 1);
        m_state = 1;
        for (int k = 0; k < 4 * BL; k++) begin
            if (k > 0) @(negedge clk);
            check("blink_hr", blink_mask, ((k / BL) % 2 == 1) ? 6'b110000 : 6'b000000);
        end
        cyc(4);

        act_adj(1, 8);
        check("run_en_set", run_en, 0);
        compare_stream("hr_inc");

        act_mode(8);
        act_adj(1, 9);
        act_mode(8);
        check("run_en_after_clr", run_en, 1);
        compare_stream("min_inc_clr");

        // Long press out of minute setting: no clear
        act_mode(8);
        act_mode(8);
        act_mode(25);
        check("run_en_long", run_en, 1);
        compare_stream("long_exit");

        // Stall: ticks two cycles apart while the datapath refuses
        cmd_ready = 1'b0;
        tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(1);
        tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(1);
        tick_1hz = 1; cyc(1); tick_1hz = 0;
        cyc(24);
        check("stall_valid", cmd_valid, 1);
        check("stall_no_xfer", got_q.size(), 0);
        cmd_ready = 1'b1;
        cyc(6);
        check("stall_drained", cmd_valid, 0);
        exp_q.push_back(F_SEC * 4 + O_INC);
        exp_q.push_back(F_SEC * 4 + O_INC);
        compare_stream("stall");

        // Long hold of up in hour setting
        act_mode(8);
        act_adj(1, 40);
        compare_stream("up_hold");

        // Glitches below the debounce window
        for (int g = 1; g < DB; g++) begin
            btn_up = 1; cyc(g); btn_up = 0; cyc(6);
            btn_down = 1; cyc(g); btn_down = 0; cyc(6);
        end
        cyc(10);
        compare_stream("glitch");

        // Down pressed while up held: only the up press counts
        btn_up = 1; cyc(8);
        btn_down = 1; cyc(8);
        btn_up = 0; cyc(6);
        btn_down = 0; cyc(14);
        exp_q.push_back(F_HOUR * 4 + O_INC);
        compare_stream("both_held");

        act_mode(25);
        check("run_en_back", run_en, 1);
        compare_stream("back_to_run");

        // Randomized action sequence against the mode model
        for (int s = 0; s < 24; s++) begin
            case ($urandom_range(0, 4))
                0: act_mode($urandom_range(6, 15));
                1: act_mode($urandom_range(22, 30));
                2: act_adj(1, $urandom_range(6, 15));
                3: act_adj(2, $urandom_range(6, 15));
                default: act_tick();
            endcase
            check("rand_run_en", run_en, (m_state == 0) ? 1 : 0);
            compare_stream("rand");
        end

        // Reset while a command is stalled in the register
        if (m_state == 0) act_mode(8);
        if (m_state == 2) act_mode(25);
        if (m_state == 0) act_mode(8);
        cmd_ready = 1'b0;
        press(1, 8);
        check("pre_rst_valid", cmd_valid, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_field", cmd_field, 0);
        check("arst_op", cmd_op, 0);
        check("arst_run_en", run_en, 1);
        check("arst_blink", blink_mask, 0);
        cyc(2);
        reset = 1'b0;
        cmd_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_state = 0;
        cyc(8);
        act_tick();
        compare_stream("post_rst_tick");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode/command sequencer for the DE10-Lite digital clock. It debounces the front-panel buttons, runs the RUN/SET_HR/SET_MIN mode state machine, and merges the 1 Hz tick and user adjustments into one command stream. That stream is the sole write port of the time-of-day counter datapath, so the datapath has a single writer. It also drives the per-digit blink mask consumed by the 7-segment decode stage.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles (20 ms at 50 MHz) before a button level is accepted.
- LONG_PRESS_CYCLES, 25_000_000: hold time (0.5 s) that qualifies a long press.
- REPEAT_CYCLES, 10_000_000: auto-repeat period (0.2 s).
- BLINK_CYCLES, 12_500_000: blink half-period (0.25 s).

Ports:
- clk  in  1  50 MHz clock.
- reset  in  1  asynchronous, active-high.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_up  in  1  raw increment button, active-high.
- btn_down  in  1  raw decrement button, active-high.
- tick_1hz  in  1  single-cycle 1 Hz strobe.
- cmd_valid  out  1  command pending.
- cmd_ready  in  1  datapath accepts; transfer when valid && ready.
- cmd_field  out  2  0=SEC, 1=MIN, 2=HOUR.
- cmd_op  out  2  0=INC, 1=DEC, 2=CLR; the datapath applies carry/wrap.
- run_en  out  1  1 = timekeeping running.
- blink_mask  out  6  bit n=1 blanks digit n (0=sec ones … 5=hour tens).

## Operation
- Each button passes a 2-flop synchronizer, then the debounce filter. Only debounced levels and edges are used below.
- FSM states: RUN, SET_HR, SET_MIN.
- btn_mode is classified on release. Short means held < LONG_PRESS_CYCLES; long means ≥ LONG_PRESS_CYCLES.
  - Short press: RUN→SET_HR→SET_MIN→RUN.
  - Leaving SET_MIN by short press emits CLR/SEC, so seconds restart at 00.
  - Long press from SET_HR or SET_MIN: return to RUN with no CLR.
  - Long press in RUN: ignored.
- run_en=0 in SET_HR and SET_MIN; run_en=1 in RUN.
- RUN:
  - tick_1hz emits INC/SEC.
  - btn_up and btn_down are ignored.
- SET_HR and SET_MIN:
  - Debounced rising edge of up emits INC on the state's field (HOUR or MIN); down emits DEC.
  - Up and down both high: neither acts; an edge arriving while the other button is held is ignored.
  - tick_1hz is ignored.
- Command register:
  - Holds one command, stable while cmd_valid && !cmd_ready.
  - A user event arriving while the register is occupied is dropped.
  - A tick arriving while occupied sets tick_pending, at most one held. It is issued after the current transfer, ahead of any new user event.
- Blink:
  - Counter toggles phase every BLINK_CYCLES.
  - SET_HR blanks bits 5:4 in the off phase; SET_MIN blanks bits 3:2.
  - Counter and phase restart (digits visible) on mode entry and on each issued adjust command.
  - blink_mask=0 in RUN.

## Timing
- Reset values: state RUN, cmd_valid 0, cmd_field 0, cmd_op 0, run_en 1, blink_mask 0, tick_pending 0, debounced levels 0, all counters 0.
- Debounce latency: 2 sync cycles plus DEBOUNCE_CYCLES after the raw level stabilises.
- Latency from an event to the datapath:
  - cmd_valid rises on the clk after the registered event, or after tick_1hz is sampled.
  - The FSM state changes on the same edge.
- A reset mid-press or mid-transfer aborts everything; the press is not re-detected until its release.
- The mode hold counter saturates at LONG_PRESS_CYCLES and does not wrap.

## Configuration
- CLOCK_SET_AUTO_REPEAT_EN defined:
  - Holding up or down in a set state beyond LONG_PRESS_CYCLES emits an extra command at the threshold, then one every REPEAT_CYCLES until release.
  - Repeats obey the drop rule.
- Undefined: exactly one command per press.

## Structure
- clock_ctrl_pkg: field enum (FLD_SEC/FLD_MIN/FLD_HOUR), op enum (OP_INC/OP_DEC/OP_CLR), FSM state enum, digit-index constants for blink_mask.
- Sub-module btn_debounce (synchronizer + stable counter + rise/fall strobes), instantiated three times.

## Test plan
All scenarios use DEBOUNCE=4, LONG=20, REPEAT=8, BLINK=6.
- RUN, tick_1hz pulse, cmd_ready=1 → one cycle of cmd_valid with SEC/INC; run_en=1; blink_mask=0.
- Short mode press → SET_HR (run_en=0). Up press → one HOUR/INC. Two short mode presses → one MIN/INC path, then CLR/SEC on exit to RUN.
- SET_MIN, mode held 25 cycles → RUN, no CLR emitted.
- cmd_ready=0 for 30 cycles in RUN with ticks 2 cycles apart → first tick held stable, second pending, third dropped; on ready, exactly two SEC/INC transfers.
- Up held 40 cycles in SET_HR → with macro: 1 + 1 + 2 = 4 INC commands; without: 1.
- Raw up glitches shorter than 4 cycles → no command. Reset asserted while cmd_valid=1 → all outputs return to reset values asynchronously.
